// File: rtl/alu_seq_pkg.sv
// Shared definitions for the FRANK6000 gen-2 ALU: opcodes, status bit
// positions and FSM state encodings.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ZEROW = 4'd0,
    OP_BNOTW = 4'd1,
    OP_NEGTW = 4'd2,
    OP_INCRW = 4'd3,
    OP_DECRW = 4'd4,
    OP_ANDWP = 4'd5,
    OP_IORWP = 4'd6,
    OP_XORWP = 4'd7,
    OP_ADDWP = 4'd8,
    OP_SUBWP = 4'd9,
    OP_CMPWP = 4'd10,
    OP_SHFLW = 4'd11,
    OP_SHFRW = 4'd12,
    OP_ADCWP = 4'd13,
    OP_MULWP = 4'd14,
    OP_RSVD  = 4'd15
  } op_e;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SHFLW) || (op == OP_SHFRW);
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU datapath. Shift ops pass W through unchanged: the
// caller only uses that result for a zero-length shift.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] wreg,
  input  logic [WIDTH-1:0] p,
  input  logic             cflag,
  output logic [WIDTH-1:0] res,
  output logic [2:0]       status
);

  logic [WIDTH:0] sum;
  logic           c;

  always_comb begin
    res = '0;
    c   = 1'b0;
    sum = '0;
    case (op_e'(opcode))
      OP_ZEROW: res = '0;
      OP_BNOTW: res = ~wreg;
      OP_NEGTW: res = '0 - wreg;
      OP_INCRW: res = wreg + WIDTH'(1);
      OP_DECRW: res = wreg - WIDTH'(1);
      OP_ANDWP: res = wreg & p;
      OP_IORWP: res = wreg | p;
      OP_XORWP: res = wreg ^ p;
      OP_ADDWP: begin
        sum = {1'b0, wreg} + {1'b0, p};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
      end
      OP_SUBWP: begin
        res = wreg - p;
        c   = (wreg < p);
      end
      OP_CMPWP: begin
        if ($signed(wreg) > $signed(p))      res = WIDTH'(1);
        else if ($signed(wreg) < $signed(p)) res = '1;
        else                                 res = '0;
      end
      OP_SHFLW, OP_SHFRW: res = wreg;
      OP_ADCWP: begin
        sum = {1'b0, wreg} + {1'b0, p} + {{WIDTH{1'b0}}, cflag};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
      end
      // MULWP (when iterative multiply is absent) and 15 land here
      default: res = '0;
    endcase
    status       = '0;
    status[ST_Z] = (res == '0);
    status[ST_N] = res[WIDTH-1];
    status[ST_C] = c;
  end

endmodule

// File: rtl/alu_seq.sv
// FRANK6000 gen-2 registered ALU with start/busy/done handshake and a
// 1-bit/cycle shifter. Define ALU_MUL_EN to add the shift-add multiplier.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] WREG,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [2:0]       status
);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] sh_q, sh_nxt;
  logic             dir_q;
  logic             cflag_q;

  logic [WIDTH-1:0] c_res;
  logic [2:0]       c_status;

  logic             accept, launch_sh, last, p_ge;
  logic [CNTW-1:0]  n;

  logic [WIDTH-1:0] it_res;
  logic             it_c;
  logic [2:0]       it_status;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_nxt;
  logic [WIDTH-1:0]   mplier_q;
  logic               launch_mul;
`endif

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .opcode (opcode),
    .wreg   (WREG),
    .p      (p),
    .cflag  (cflag_q),
    .res    (c_res),
    .status (c_status)
  );

  // Shift counts at or beyond WIDTH saturate, flushing every bit out.
  assign p_ge      = (p >= WIDTH'(WIDTH));
  assign n         = p_ge ? CNTW'(WIDTH) : CNTW'(p);
  assign accept    = start && (state_q == S_IDLE);
  assign launch_sh = accept && is_shift_op(opcode) && (n != '0);
  assign last      = (cnt_q == CNTW'(1));
  assign sh_nxt    = dir_q ? (sh_q >> 1) : (sh_q << 1);

`ifdef ALU_MUL_EN
  assign launch_mul = accept && (opcode == OP_MULWP);
  assign acc_nxt    = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // Final result/flags of an iterative op, taken on its last edge
  always_comb begin
    it_res = sh_nxt;
    it_c   = 1'b0;
`ifdef ALU_MUL_EN
    if (state_q == S_MUL) begin
      it_res = acc_nxt[WIDTH-1:0];
      it_c   = |acc_nxt[2*WIDTH-1:WIDTH];
    end
`endif
    it_status       = '0;
    it_status[ST_Z] = (it_res == '0);
    it_status[ST_N] = it_res[WIDTH-1];
    it_status[ST_C] = it_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (launch_sh) state_d = S_SHIFT;
`ifdef ALU_MUL_EN
        else if (launch_mul) state_d = S_MUL;
`endif
      end
      default: if (last) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res     <= '0;
      status  <= '0;
      done    <= 1'b0;
      cflag_q <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      dir_q   <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        sh_q  <= WREG;
        dir_q <= (opcode == OP_SHFRW);
        cnt_q <= n;
`ifdef ALU_MUL_EN
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, WREG};
        mplier_q <= p;
        if (launch_mul) cnt_q <= CNTW'(WIDTH);
        if (!launch_sh && !launch_mul) begin
`else
        if (!launch_sh) begin
`endif
          res     <= c_res;
          status  <= c_status;
          cflag_q <= c_status[ST_C];
          done    <= 1'b1;
        end
      end else if (state_q != S_IDLE) begin
        sh_q  <= sh_nxt;
        cnt_q <= cnt_q - CNTW'(1);
`ifdef ALU_MUL_EN
        acc_q    <= acc_nxt;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
`endif
        if (last) begin
          res     <= it_res;
          status  <= it_status;
          cflag_q <= it_status[ST_C];
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed table, handshake
// corner sequences and randomized ops against an arithmetic model.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] WREG, p;
  logic         busy, done;
  logic [W-1:0] res;
  logic [2:0]   status;

  int nvec = 0;
  int nerr = 0;
  bit m_cf = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .CNTW(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opcode (opcode),
    .WREG   (WREG),
    .p      (p),
    .busy   (busy),
    .done   (done),
    .res    (res),
    .status (status)
  );

  typedef struct {
    int    op;
    int    w;
    int    pp;
    int    r;
    int    st;
    int    lat;
    string nm;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on the op definitions
  function automatic void model(input int op, input int w, input int pp, input bit cf,
                                output int r, output int st, output int lat);
    int c, n, sw, sp;
    longint t;
    c = 0; lat = 1; r = 0;
    case (op)
      0:  r = 0;
      1:  r = ~w;
      2:  r = -w;
      3:  r = w + 1;
      4:  r = w - 1;
      5:  r = w & pp;
      6:  r = w | pp;
      7:  r = w ^ pp;
      8:  begin t = w + pp; c = (t > MASK); r = int'(t); end
      9:  begin r = w - pp; c = (w < pp); end
      10: begin
        sw = (w >= 128) ? w - 256 : w;
        sp = (pp >= 128) ? pp - 256 : pp;
        r  = (sw > sp) ? 1 : (sw < sp) ? -1 : 0;
      end
      11, 12: begin
        n   = (pp > W) ? W : pp;
        r   = (op == 11) ? (w << n) : (w >> n);
        lat = 1 + n;
      end
      13: begin t = w + pp + cf; c = (t > MASK); r = int'(t); end
`ifdef ALU_MUL_EN
      14: begin t = w * pp; c = (t > MASK); r = int'(t); lat = 1 + W; end
`endif
      default: r = 0;
    endcase
    r  = r & MASK;
    st = (c << 2) | (((r >> (W - 1)) & 1) << 1) | ((r == 0) ? 1 : 0);
  endfunction

  task automatic run_op(input int op, input int w, input int pp,
                        output logic [31:0] r, output logic [31:0] st,
                        output int lat, output int bsy);
    @(negedge clk);
    start = 1'b1; opcode = 4'(op); WREG = W'(w); p = W'(pp);
    lat = 0; bsy = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bsy++;
    end while (!done && lat < 64);
    r = 32'(res); st = 32'(status);
  endtask

  initial begin
    logic [31:0] gr, gs;
    int lat, bsy, er, es, el, op, w, pp, bcnt;

    rst = 1'b1; start = 1'b0; opcode = '0; WREG = '0; p = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res", 32'(res), 0);
    chk("rst_status", 32'(status), 0);
    rst = 1'b0;

    tbl.push_back('{8, 200, 100, 44, 4, 1, "add_cout"});
    tbl.push_back('{13, 1, 1, 3, 0, 1, "adc_cin"});
    tbl.push_back('{11, 'hCC, 3, 'h60, 0, 4, "shl3"});
    tbl.push_back('{11, 'hCC, 9, 0, 1, 9, "shl9_sat"});
    tbl.push_back('{12, 'hCC, 3, 'h19, 0, 4, "shr3"});
    tbl.push_back('{12, 'h80, 8, 0, 1, 9, "shr8"});
    tbl.push_back('{12, 'h80, 7, 1, 0, 8, "shr7"});
    tbl.push_back('{11, 'h5A, 0, 'h5A, 0, 1, "shl0"});
    tbl.push_back('{2, 'h80, 0, 'h80, 2, 1, "neg_min"});
    tbl.push_back('{2, 1, 0, 'hFF, 2, 1, "neg_one"});
    tbl.push_back('{10, 80, 90, 'hFF, 2, 1, "cmp_lt"});
    tbl.push_back('{10, 90, 80, 1, 0, 1, "cmp_gt"});
    tbl.push_back('{10, 5, 5, 0, 1, 1, "cmp_eq"});
    tbl.push_back('{10, 'h80, 1, 'hFF, 2, 1, "cmp_signed"});
    tbl.push_back('{9, 3, 5, 'hFE, 6, 1, "sub_borrow"});
    tbl.push_back('{13, 'h10, 'h20, 'h31, 0, 1, "adc_cf1"});
    tbl.push_back('{8, 'hFF, 1, 0, 5, 1, "add_wrap"});
    tbl.push_back('{13, 'hFF, 0, 0, 5, 1, "adc_wrap"});
    tbl.push_back('{3, 'hFF, 0, 0, 1, 1, "inc_wrap"});
    tbl.push_back('{4, 0, 0, 'hFF, 2, 1, "dec_wrap"});
    tbl.push_back('{5, 'hF0, 'h3C, 'h30, 0, 1, "and"});
    tbl.push_back('{6, 'hF0, 'h0F, 'hFF, 2, 1, "ior"});
    tbl.push_back('{7, 'hAA, 'hAA, 0, 1, 1, "xor"});
    tbl.push_back('{1, 'h0F, 0, 'hF0, 2, 1, "bnot"});
    tbl.push_back('{0, 'h55, 0, 0, 1, 1, "zero"});
    tbl.push_back('{15, 'h55, 'h11, 0, 1, 1, "reserved"});
`ifdef ALU_MUL_EN
    tbl.push_back('{14, 20, 20, 'h90, 6, 9, "mul"});
`else
    tbl.push_back('{14, 20, 20, 0, 1, 1, "mul_rsvd"});
`endif
    tbl.push_back('{9, 5, 3, 2, 0, 1, "sub"});

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].w, tbl[i].pp, gr, gs, lat, bsy);
      chk({tbl[i].nm, "_res"}, gr, tbl[i].r);
      chk({tbl[i].nm, "_st"}, gs, tbl[i].st);
      chk({tbl[i].nm, "_lat"}, lat, tbl[i].lat);
      chk({tbl[i].nm, "_busy"}, bsy, tbl[i].lat - 1);
      m_cf = tbl[i].st[2];
    end

    // Reset in the middle of a shift, with cflag=1 and nonzero outputs
    run_op(8, 'hFF, 2, gr, gs, lat, bsy);
    chk("pre_rst_res", gr, 1);
    @(negedge clk);
    start = 1'b1; opcode = 4'd11; WREG = 8'h11; p = 8'd5;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_res", 32'(res), 0);
    chk("midrst_status", 32'(status), 0);
    @(negedge clk); rst = 1'b0;
    m_cf = 1'b0;
    run_op(13, 1, 1, gr, gs, lat, bsy);
    chk("postrst_adc", gr, 2);
    run_op(8, 1, 1, gr, gs, lat, bsy);
    chk("postrst_add", gr, 2);
    chk("postrst_add_st", gs, 0);

    // start held high through a busy shift with new operands, then back-to-back
    @(negedge clk);
    start = 1'b1; opcode = 4'd12; WREG = 8'hCC; p = 8'd3;
    @(negedge clk);
    opcode = 4'd8; WREG = 8'd1; p = 8'd1;
    lat = 1; bcnt = 0;
    while (!done && lat < 64) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk("hold_lat", lat, 4);
    chk("hold_busy", bcnt, 3);
    chk("hold_res", 32'(res), 'h19);
    chk("hold_st", 32'(status), 0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done", 32'(done), 1);
    chk("b2b_res", 32'(res), 2);
    @(negedge clk);
    chk("b2b_pulse", 32'(done), 0);
    m_cf = 1'b0;

    for (int k = 0; k < 200; k++) begin
      op = $urandom_range(0, 15);
      w  = $urandom_range(0, MASK);
      pp = (op == 11 || op == 12) ? $urandom_range(0, 12) : $urandom_range(0, MASK);
      model(op, w, pp, m_cf, er, es, el);
      run_op(op, w, pp, gr, gs, lat, bsy);
      chk($sformatf("rnd%0d_op%0d_res", k, op), gr, er);
      chk($sformatf("rnd%0d_op%0d_st", k, op), gs, es);
      chk($sformatf("rnd%0d_op%0d_lat", k, op), lat, el);
      m_cf = es[2];
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
